// File: rtl/if_fetch_buffer_pkg.sv
// Shared fetch-stage constants: bus widths, reset words and default buffer sizing.
package if_fetch_buffer_pkg;

  localparam int          InstAddrBus      = 32;
  localparam int          InstBus          = 32;
  localparam logic [31:0] ZeroWord         = 32'h0000_0000;
  localparam logic [31:0] NopInst          = 32'h0000_0000;
  localparam int          IfFifoDepth      = 2;
  localparam int          IfMaxOutstanding = 2;

endpackage

// File: rtl/if_fetch_buffer_sync_fifo.sv
// Small synchronous FIFO with a registered head word. The head register keeps
// its last value when the FIFO drains or is cleared, so consumers see a stable
// word while the valid indication is low.
module if_sync_fifo #(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 2,
  parameter logic [WIDTH-1:0] RESET_HEAD = '0,
  parameter int               CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] left;
  logic             do_pop;

  // A pop of an empty FIFO is ignored; DEPTH is a power of two so pointers wrap freely.
  assign do_pop     = pop & (count_q != '0);
  assign left       = count_q - CNT_W'(do_pop);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);
  assign count      = count_q;

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and head word; clear empties the FIFO but keeps the head word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      head    <= RESET_HEAD;
    end else if (clr) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      rd_ptr  <= rd_ptr_nxt;
      wr_ptr  <= wr_ptr + PTR_W'(push);
      count_q <= left + CNT_W'(push);
      if (left != '0) head <= mem[rd_ptr_nxt];
      else if (push)  head <= push_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push && !pop && !clr) |-> (count_q != CNT_W'(DEPTH)));

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch buffer: issues in-order fetches under a credit limit, pairs
// each response with its PC and queues the pairs for decode. A redirect drops
// buffered entries and marks every in-flight fetch for discard.
module if_fetch_buffer
  import if_fetch_buffer_pkg::*;
#(
  parameter int FIFO_DEPTH      = IfFifoDepth,
  parameter int MAX_OUTSTANDING = IfMaxOutstanding,
  parameter int ADDR_W          = InstAddrBus,
  parameter int DATA_W          = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  output logic              stall_req_o,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_gnt_i,
  input  logic              inst_rvalid_i,
  input  logic [DATA_W-1:0] inst_rdata_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
  input  logic              id_ready_i
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [OUT_W-1:0]  outstanding;
  logic [OUT_W-1:0]  discard;
  logic [OUT_W-1:0]  pcq_count;
  logic [CNT_W-1:0]  fifo_count;
  logic [ADDR_W-1:0] resp_pc;
  logic [ENT_W-1:0]  fifo_head;
  logic              credit_ok;
  logic              issue;
  logic              drop_resp;
  logic              fifo_push;
  logic              fifo_pop;

  // A request may only issue when its response is guaranteed a buffer slot,
  // so responses never need back-pressure.
  assign credit_ok = (32'(outstanding) + 32'(fifo_count) < 32'(FIFO_DEPTH)) &&
                     (32'(outstanding) < 32'(MAX_OUTSTANDING));

  assign inst_req_o  = ~rst & ce_i & ~flush_i & credit_ok;
  assign inst_addr_o = rst ? '0 : {pc_i[ADDR_W-1:2], 2'b00};
  assign issue       = inst_req_o & inst_gnt_i;
  // No stall on a redirect cycle: the PC register loads the target next cycle.
  assign stall_req_o = ~rst & ce_i & ~flush_i & ~issue;

  assign drop_resp = (discard != '0);
  assign fifo_push = inst_rvalid_i & ~drop_resp;
  assign fifo_pop  = id_valid_o & id_ready_i;

  assign id_valid_o           = (fifo_count != '0);
  assign {id_pc_o, id_inst_o} = fifo_head;

  // PCs of granted requests, popped by responses in request order.
  if_sync_fifo #(
    .WIDTH      (ADDR_W),
    .DEPTH      (MAX_OUTSTANDING),
    .RESET_HEAD (ADDR_W'(ZeroWord)),
    .CNT_W      (OUT_W)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .clr       (1'b0),
    .push      (issue),
    .push_data (pc_i),
    .pop       (inst_rvalid_i),
    .head      (resp_pc),
    .count     (pcq_count)
  );

  // {pc, inst} pairs toward decode; a redirect clears it outright.
  if_sync_fifo #(
    .WIDTH      (ENT_W),
    .DEPTH      (FIFO_DEPTH),
    .RESET_HEAD ({ADDR_W'(ZeroWord), DATA_W'(NopInst)}),
    .CNT_W      (CNT_W)
  ) u_inst_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush_i),
    .push      (fifo_push),
    .push_data ({resp_pc, inst_rdata_i}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // In-flight and pending-discard counters; on redirect every fetch still in
  // flight after this cycle's response becomes a discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + OUT_W'(issue) - OUT_W'(inst_rvalid_i);
      if (flush_i)                         discard <= outstanding - OUT_W'(inst_rvalid_i);
      else if (inst_rvalid_i && drop_resp) discard <= discard - OUT_W'(1);
    end
  end

  a_resp_expected: assert property (@(posedge clk) disable iff (rst)
    inst_rvalid_i |-> (outstanding != '0));

  a_pcq_tracks: assert property (@(posedge clk) disable iff (rst)
    pcq_count == outstanding);

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: directed scenarios plus randomized traffic against
// a queue-based reference model and an in-order variable-latency memory.
module tb_if_fetch_buffer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int MAXO  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc_i;
  logic          ce_i;
  logic          flush_i;
  logic          stall_req_o;
  logic          inst_req_o;
  logic [AW-1:0] inst_addr_o;
  logic          inst_gnt_i;
  logic          inst_rvalid_i;
  logic [DW-1:0] inst_rdata_i;
  logic          id_valid_o;
  logic [AW-1:0] id_pc_o;
  logic [DW-1:0] id_inst_o;
  logic          id_ready_i;

  always #5 clk = ~clk;

  if_fetch_buffer #(
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .ADDR_W          (AW),
    .DATA_W          (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .ce_i          (ce_i),
    .flush_i       (flush_i),
    .stall_req_o   (stall_req_o),
    .inst_req_o    (inst_req_o),
    .inst_addr_o   (inst_addr_o),
    .inst_gnt_i    (inst_gnt_i),
    .inst_rvalid_i (inst_rvalid_i),
    .inst_rdata_i  (inst_rdata_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .id_ready_i    (id_ready_i)
  );

  typedef struct { logic [AW-1:0] pc; bit drop; } flight_t;
  typedef struct { logic [AW-1:0] pc; logic [DW-1:0] inst; } entry_t;
  typedef struct { logic [AW-1:0] addr; int due; } memreq_t;

  flight_t inflight[$];
  entry_t  buffer[$];
  memreq_t mq[$];

  logic [AW-1:0] last_pc;
  logic [DW-1:0] last_inst;
  logic [AW-1:0] cur_pc;
  logic [AW-1:0] k_target;
  logic [AW-1:0] hold_pc;
  bit            k_ce, k_gnt, k_ready, k_flush;
  bit            exp_req, exp_stall;
  int            k_lat;
  int            cyc;
  int            n_vec;
  int            n_bad;
  bit            found;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: no valid entry within cycle budget (cycle %0d)", name, cyc);
  endtask

  // Apply this cycle's inputs, let them settle, and compare every output with the model.
  task automatic drive();
    pc_i       = cur_pc;
    ce_i       = k_ce;
    flush_i    = k_flush;
    inst_gnt_i = k_gnt;
    id_ready_i = k_ready;
    inst_rvalid_i = 1'b0;
    inst_rdata_i  = 32'hDEAD_BEEF;
    if (mq.size() > 0) begin
      if (mq[0].due <= cyc) begin
        inst_rvalid_i = 1'b1;
        inst_rdata_i  = mem_word(mq[0].addr);
      end
    end
    #1;
    exp_req   = k_ce && !k_flush && (inflight.size() + buffer.size() < DEPTH) &&
                (inflight.size() < MAXO);
    exp_stall = k_ce && !k_flush && !(exp_req && k_gnt);
    check_bit("inst_req", inst_req_o, exp_req);
    check_bit("stall_req", stall_req_o, exp_stall);
    check_word("inst_addr", inst_addr_o, {cur_pc[AW-1:2], 2'b00});
    check_bit("id_valid", id_valid_o, buffer.size() > 0);
    if (buffer.size() > 0) begin
      check_word("id_pc", id_pc_o, buffer[0].pc);
      check_word("id_inst", id_inst_o, buffer[0].inst);
    end else begin
      check_word("id_pc_hold", id_pc_o, last_pc);
      check_word("id_inst_hold", id_inst_o, last_inst);
    end
  endtask

  // Move the model, memory and PC register across the clock edge.
  task automatic advance();
    bit      issued;
    flight_t f;
    memreq_t m;
    issued = exp_req && k_gnt;
    if (buffer.size() > 0) begin
      last_pc   = buffer[0].pc;
      last_inst = buffer[0].inst;
      if (k_ready) void'(buffer.pop_front());
    end
    if (inst_rvalid_i && mq.size() > 0 && inflight.size() > 0) begin
      m = mq.pop_front();
      f = inflight.pop_front();
      if (!f.drop && !k_flush) buffer.push_back('{f.pc, mem_word(m.addr)});
    end
    if (k_flush) begin
      buffer.delete();
      foreach (inflight[i]) inflight[i].drop = 1'b1;
    end
    if (issued) begin
      inflight.push_back('{cur_pc, 1'b0});
      mq.push_back('{{cur_pc[AW-1:2], 2'b00}, cyc + k_lat});
    end
    if (k_flush)                 cur_pc = k_target;
    else if (k_ce && !exp_stall) cur_pc = cur_pc + 32'd4;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    drive();
    advance();
  endtask

  task automatic drain();
    k_ce = 0; k_flush = 0; k_ready = 1; k_gnt = 1;
    repeat (8) tick();
  endtask

  task automatic randomize_knobs();
    k_ce     = ($urandom % 8) != 0;
    k_gnt    = ($urandom % 4) != 0;
    k_ready  = ($urandom % 3) != 0;
    k_flush  = ($urandom % 20) == 0;
    k_target = $urandom & 32'hFFFF_FFFC;
    k_lat    = $urandom_range(1, 4);
  endtask

  task automatic wait_first(input string name, input logic [AW-1:0] pc_exp);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      drive();
      if (id_valid_o) begin
        check_word({name, "_pc"}, id_pc_o, pc_exp);
        check_word({name, "_inst"}, id_inst_o, mem_word(pc_exp));
        found = 1;
      end
      advance();
      if (found) break;
    end
    if (!found) timeout_fail(name);
  endtask

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0;
    last_pc = '0; last_inst = '0;
    rst = 1'b1;
    pc_i = 32'h0000_1234; ce_i = 1'b1; flush_i = 1'b0; inst_gnt_i = 1'b1;
    inst_rvalid_i = 1'b0; inst_rdata_i = '0; id_ready_i = 1'b1;
    #1;
    check_bit("rst_req", inst_req_o, 1'b0);
    check_bit("rst_stall", stall_req_o, 1'b0);
    check_bit("rst_id_valid", id_valid_o, 1'b0);
    check_word("rst_id_pc", id_pc_o, 32'h0);
    check_word("rst_id_inst", id_inst_o, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single-cycle memory, continuous fetch from the boot vector.
    cur_pc = 32'hBFC0_0000;
    k_ce = 1; k_gnt = 1; k_ready = 1; k_flush = 0; k_lat = 1; k_target = '0;
    for (int i = 0; i < 12; i++) begin
      drive();
      if (i == 0) begin
        check_bit("boot_req", inst_req_o, 1'b1);
        check_word("boot_addr", inst_addr_o, 32'hBFC0_0000);
      end
      if (i == 1) check_bit("boot_no_bypass", id_valid_o, 1'b0);
      if (i == 2) begin
        check_bit("boot_valid", id_valid_o, 1'b1);
        check_word("boot_pc0", id_pc_o, 32'hBFC0_0000);
        check_word("boot_inst0", id_inst_o, 32'h1A65_FFFF);
      end
      if (i == 3) begin
        check_word("boot_pc1", id_pc_o, 32'hBFC0_0004);
        check_word("boot_inst1", id_inst_o, 32'h1A65_FFFB);
      end
      advance();
    end

    // Decode stalled: buffer fills and fetch backs off.
    k_ready = 0;
    for (int i = 0; i < 6; i++) begin
      drive();
      if (i == 5) begin
        check_bit("full_valid", id_valid_o, 1'b1);
        check_bit("full_req", inst_req_o, 1'b0);
        check_bit("full_stall", stall_req_o, 1'b1);
      end
      advance();
    end
    k_ready = 1;
    repeat (8) tick();

    // Memory refuses grants for three cycles.
    drain();
    k_ce = 1; k_gnt = 0;
    hold_pc = cur_pc;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) k_gnt = 1;
      drive();
      check_bit("gnt_req", inst_req_o, 1'b1);
      check_word("gnt_addr", inst_addr_o, hold_pc);
      check_bit("gnt_stall", stall_req_o, (i == 3) ? 1'b0 : 1'b1);
      advance();
    end

    // Redirect with two fetches in flight.
    drain();
    cur_pc = 32'h0000_0100; k_lat = 3; k_ce = 1;
    tick(); tick();
    k_flush = 1; k_target = 32'h0000_0200;
    tick();
    k_flush = 0; k_lat = 1;
    wait_first("redir", 32'h0000_0200);

    // Redirect coinciding with a response and a decode pop.
    drain();
    cur_pc = 32'h0000_0300; k_lat = 1; k_ce = 1; k_ready = 0;
    tick(); tick();
    k_flush = 1; k_ready = 1; k_target = 32'h0000_0400;
    tick();
    k_flush = 0;
    drive();
    check_bit("flush_empty", id_valid_o, 1'b0);
    advance();
    wait_first("flush_resp", 32'h0000_0400);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      randomize_knobs();
      tick();
    end

    // Reset in the middle of two outstanding fetches.
    drain();
    cur_pc = 32'h0000_0800; k_lat = 3; k_ce = 1;
    tick(); tick();
    drive();
    rst = 1'b1;
    inst_rvalid_i = 1'b0;
    #1;
    check_bit("mid_rst_req", inst_req_o, 1'b0);
    check_bit("mid_rst_stall", stall_req_o, 1'b0);
    check_word("mid_rst_addr", inst_addr_o, 32'h0);
    check_bit("mid_rst_valid", id_valid_o, 1'b0);
    check_word("mid_rst_pc", id_pc_o, 32'h0);
    check_word("mid_rst_inst", id_inst_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc++;
    inflight.delete(); buffer.delete(); mq.delete();
    last_pc = '0; last_inst = '0;
    cur_pc = 32'h8000_0000;

    for (int i = 0; i < 500; i++) begin
      randomize_knobs();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
